// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer: six fixed phases timed in one-second ticks,
// with a registered load strobe and phase duration for an external countdown display.
module traffic_phase_ctrl #(
  parameter logic [6:0] T_GREEN  = 7'd25,
  parameter logic [6:0] T_YELLOW = 7'd3,
  parameter logic [6:0] T_ALLRED = 7'd2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       hold,
  output logic       load,
  output logic [6:0] count,
  output logic [6:0] remaining,
  output logic [2:0] phase,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } state_t;

  state_t     state, state_next;
  logic [6:0] remaining_next, count_next;
  logic       load_next;
  logic       started, start_strobe;
  logic       advance;

  function automatic state_t next_of(input state_t s);
    case (s)
      NS_GREEN:  next_of = NS_YELLOW;
      NS_YELLOW: next_of = ALLRED_A;
      ALLRED_A:  next_of = EW_GREEN;
      EW_GREEN:  next_of = EW_YELLOW;
      EW_YELLOW: next_of = ALLRED_B;
      default:   next_of = NS_GREEN;
    endcase
  endfunction

  function automatic logic [6:0] dur_of(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   dur_of = T_GREEN;
      NS_YELLOW, EW_YELLOW: dur_of = T_YELLOW;
      default:              dur_of = T_ALLRED;
    endcase
  endfunction

  // Ticks are ignored on the first edge after reset and during the startup strobe cycle.
  assign advance = tick && !hold && started && !start_strobe;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state        <= NS_GREEN;
      remaining    <= T_GREEN;
      count        <= T_GREEN;
      load         <= 1'b1;
      started      <= 1'b0;
      start_strobe <= 1'b0;
    end else begin
      state        <= state_next;
      remaining    <= remaining_next;
      count        <= count_next;
      load         <= load_next;
      started      <= 1'b1;
      start_strobe <= !started;
    end
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    count_next     = count;
    load_next      = 1'b1;
    if (!started) begin
      load_next = 1'b0;
    end else if (advance) begin
      if (remaining == 7'd1) begin
        state_next     = next_of(state);
        remaining_next = dur_of(next_of(state));
        count_next     = dur_of(next_of(state));
        load_next      = 1'b0;
      end else begin
        remaining_next = remaining - 7'd1;
      end
    end
  end

  // Lights and phase depend only on the state register.
  always_comb begin
    ns_light = 3'b100;
    ew_light = 3'b100;
    case (state)
      NS_GREEN:  ns_light = 3'b001;
      NS_YELLOW: ns_light = 3'b010;
      EW_GREEN:  ew_light = 3'b001;
      EW_YELLOW: ew_light = 3'b010;
      default: ;
    endcase
  end

  assign phase = state;

endmodule
